// File: rtl/md_rd_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_rd_arb_if
//  Description : Bundle of the two requester channels and the pixel-buffer
//                read port served by md_rd_arb. The slave modport is the
//                arbiter's view; the master modport is the view of the
//                requesters plus the pixel buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface md_rd_arb_if;
    // Requester A (pre-intra 8x8 fetch)
    logic         a_req;
    logic         a_lock;
    logic         a_sel;
    logic [1:0]   a_size;
    logic [3:0]   a_x;
    logic [3:0]   a_y;
    logic [4:0]   a_idx;
    logic         a_gnt;
    logic         a_vld;
    // Requester B (intra/RDO fetch)
    logic         b_req;
    logic         b_lock;
    logic         b_sel;
    logic [1:0]   b_size;
    logic [3:0]   b_x;
    logic [3:0]   b_y;
    logic [4:0]   b_idx;
    logic         b_gnt;
    logic         b_vld;
    // Shared return data
    logic [255:0] rd_data_o;
    // Pixel-buffer read port
    logic         md_ren_o;
    logic         md_sel_o;
    logic [1:0]   md_size_o;
    logic [3:0]   md_4x4_x_o;
    logic [3:0]   md_4x4_y_o;
    logic [4:0]   md_idx_o;
    logic [255:0] md_data_i;

    modport slave (
        input  a_req, a_lock, a_sel, a_size, a_x, a_y, a_idx,
        input  b_req, b_lock, b_sel, b_size, b_x, b_y, b_idx,
        input  md_data_i,
        output a_gnt, a_vld, b_gnt, b_vld, rd_data_o,
        output md_ren_o, md_sel_o, md_size_o, md_4x4_x_o, md_4x4_y_o, md_idx_o
    );

    modport master (
        output a_req, a_lock, a_sel, a_size, a_x, a_y, a_idx,
        output b_req, b_lock, b_sel, b_size, b_x, b_y, b_idx,
        output md_data_i,
        input  a_gnt, a_vld, b_gnt, b_vld, rd_data_o,
        input  md_ren_o, md_sel_o, md_size_o, md_4x4_x_o, md_4x4_y_o, md_idx_o
    );
endinterface
`default_nettype wire

// File: rtl/md_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : md_rd_arb
//  Description : Two-requester arbiter for the single original-pixel read
//                port of the LCU pixel buffer. B has default priority, A is
//                protected from starvation, lock holds burst ownership, and
//                a tag pipe steers returned data to the right requester.
//                Optional macro MD_ARB_STAT_EN adds grant/starvation stats.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_rd_arb #(
    parameter int STARVE_MAX = 15,  // 1..15
    parameter int RD_LAT     = 1    // 1 or 2
) (
    input  wire logic   clk,
    input  wire logic   rstn,       // synchronous, active-high despite the name
    md_rd_arb_if.slave  bus
`ifdef MD_ARB_STAT_EN
    ,
    input  wire logic   stat_clr,
    output logic [15:0] stat_a_cnt,
    output logic [15:0] stat_b_cnt,
    output logic [3:0]  stat_starve_max
`endif
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic [1:0]    tag_q [RD_LAT];
    logic [1:0]    vld_q;
    logic [255:0]  rd_data_q;
    logic          gnt_a, gnt_b;

    // Grant decision and next ownership; nothing is granted while reset is held
    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        state_d = state_q;
        if (!rstn) begin
            case (state_q)
                IDLE: begin
                    if (bus.a_req && (!bus.b_req || starve_q == C_STARVE_MAX)) begin
                        gnt_a = 1'b1;
                        if (bus.a_lock) state_d = OWN_A;
                    end else if (bus.b_req) begin
                        gnt_b = 1'b1;
                        if (bus.b_lock) state_d = OWN_B;
                    end
                end
                OWN_A: begin
                    gnt_a = bus.a_req;
                    if (!bus.a_lock) state_d = IDLE;
                end
                OWN_B: begin
                    gnt_b = bus.b_req;
                    if (!bus.b_lock) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Starvation counter: counts denied A cycles, saturating, cleared on an A grant
    always_comb begin
        starve_d = starve_q;
        if (gnt_a)
            starve_d = 4'd0;
        else if (bus.a_req && starve_q != C_STARVE_MAX)
            starve_d = starve_q + 4'd1;
    end

    // Ownership FSM and starvation counter state
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Tag pipe follows each read through the buffer latency; rd_data is its registered copy
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= 2'b00;
            vld_q     <= 2'b00;
            rd_data_q <= '0;
        end else begin
            tag_q[0] <= {gnt_a, gnt_b};
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            vld_q     <= tag_q[RD_LAT-1];
            rd_data_q <= bus.md_data_i;
        end
    end

    assign bus.a_gnt      = gnt_a;
    assign bus.b_gnt      = gnt_b;
    assign bus.a_vld      = vld_q[1];
    assign bus.b_vld      = vld_q[0];
    assign bus.rd_data_o  = rd_data_q;
    assign bus.md_ren_o   = gnt_a | gnt_b;
    // Fields of the granted side; zero when the port is idle
    assign bus.md_sel_o   = gnt_a ? bus.a_sel  : (gnt_b ? bus.b_sel  : 1'b0);
    assign bus.md_size_o  = gnt_a ? bus.a_size : (gnt_b ? bus.b_size : 2'd0);
    assign bus.md_4x4_x_o = gnt_a ? bus.a_x    : (gnt_b ? bus.b_x    : 4'd0);
    assign bus.md_4x4_y_o = gnt_a ? bus.a_y    : (gnt_b ? bus.b_y    : 4'd0);
    assign bus.md_idx_o   = gnt_a ? bus.a_idx  : (gnt_b ? bus.b_idx  : 5'd0);

`ifdef MD_ARB_STAT_EN
    logic [15:0] stat_a_q, stat_b_q;
    logic [3:0]  stat_peak_q;

    // Saturating grant counters and peak starvation level
    always_ff @(posedge clk) begin
        if (rstn || stat_clr) begin
            stat_a_q    <= 16'd0;
            stat_b_q    <= 16'd0;
            stat_peak_q <= 4'd0;
        end else begin
            if (gnt_a && stat_a_q != 16'hFFFF) stat_a_q <= stat_a_q + 16'd1;
            if (gnt_b && stat_b_q != 16'hFFFF) stat_b_q <= stat_b_q + 16'd1;
            if (starve_q > stat_peak_q) stat_peak_q <= starve_q;
        end
    end

    assign stat_a_cnt      = stat_a_q;
    assign stat_b_cnt      = stat_b_q;
    assign stat_starve_max = stat_peak_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_md_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_rd_arb
//  Description : Directed bench for md_rd_arb with a queue scoreboard. The
//                stimulus pushes every expected data return; a monitor pops
//                and compares whenever a_vld/b_vld is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_rd_arb;
    localparam int RD_LAT = 1;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   cyc  = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    md_rd_arb_if bus();

`ifdef MD_ARB_STAT_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_a_cnt, stat_b_cnt;
    logic [3:0]  stat_starve_max;
`endif

    md_rd_arb #(.STARVE_MAX(15), .RD_LAT(RD_LAT)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef MD_ARB_STAT_EN
        ,
        .stat_clr        (stat_clr),
        .stat_a_cnt      (stat_a_cnt),
        .stat_b_cnt      (stat_b_cnt),
        .stat_starve_max (stat_starve_max)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mk_key(input logic s, input logic [1:0] z,
                                           input logic [3:0] x, input logic [3:0] y,
                                           input logic [4:0] i);
        return {s, z, x, y, i};
    endfunction

    function automatic logic [255:0] data_fn(input logic [15:0] k);
        logic [255:0] d;
        for (int j = 0; j < 16; j++) d[j*16 +: 16] = k ^ 16'(j * 4951);
        return d;
    endfunction

    // Pixel-buffer model: data for the presented address appears RD_LAT cycles later
    logic [255:0] mem_pipe [RD_LAT];
    always @(posedge clk) begin
        mem_pipe[0] <= bus.md_ren_o ? data_fn(mk_key(bus.md_sel_o, bus.md_size_o, bus.md_4x4_x_o,
                                                      bus.md_4x4_y_o, bus.md_idx_o))
                                    : {8{32'hDEADBEEF}};
        for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign bus.md_data_i = mem_pipe[RD_LAT-1];

    typedef struct {
        logic         is_a;
        logic [255:0] data;
        int           at_cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every presented vld must match the oldest expected return
    always @(negedge clk) begin
        if (bus.a_vld === 1'b1 || bus.b_vld === 1'b1) begin
            n_vec++;
            if (bus.a_vld && bus.b_vld) begin
                n_bad++;
                $display("FAIL vld_both: a_vld=1 b_vld=1 expected one-hot (cycle %0d)", cyc);
            end else if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL vld_unexpected: a_vld=%0b b_vld=%0b expected none (cycle %0d)",
                         bus.a_vld, bus.b_vld, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (bus.a_vld !== e.is_a || bus.rd_data_o !== e.data || cyc != e.at_cyc) begin
                    n_bad++;
                    $display("FAIL vld_ret: got a=%0b cyc=%0d data=%0h expected a=%0b cyc=%0d data=%0h",
                             bus.a_vld, cyc, bus.rd_data_o, e.is_a, e.at_cyc, e.data);
                end
            end
        end
    end

    // One cycle: inputs are already set; check grants/fields and log expected returns
    task automatic tick(input logic ea, input logic eb);
        logic [15:0] ka, kb, kexp;
        exp_t e;
        #1;
        ka   = mk_key(bus.a_sel, bus.a_size, bus.a_x, bus.a_y, bus.a_idx);
        kb   = mk_key(bus.b_sel, bus.b_size, bus.b_x, bus.b_y, bus.b_idx);
        kexp = ea ? ka : (eb ? kb : 16'd0);
        chk("gnt", 256'({bus.a_gnt, bus.b_gnt}), 256'({ea, eb}));
        chk("ren", 256'(bus.md_ren_o), 256'(ea | eb));
        chk("fields", 256'(mk_key(bus.md_sel_o, bus.md_size_o, bus.md_4x4_x_o,
                                  bus.md_4x4_y_o, bus.md_idx_o)), 256'(kexp));
        if (ea || eb) begin
            e.is_a   = ea;
            e.data   = data_fn(kexp);
            e.at_cyc = cyc + RD_LAT + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t keep[$];
        bus.a_req = 1'b1; bus.a_lock = 1'b0; bus.a_sel = 1'b0; bus.a_size = 2'd1;
        bus.a_x   = 4'd3; bus.a_y    = 4'd5; bus.a_idx = 5'd0;
        bus.b_req = 1'b1; bus.b_lock = 1'b0; bus.b_sel = 1'b1; bus.b_size = 2'd2;
        bus.b_x   = 4'd9; bus.b_y    = 4'd12; bus.b_idx = 5'd0;

        // Reset held with both requesting: nothing granted, outputs cleared
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_vld", 256'({bus.a_vld, bus.b_vld}), 256'(0));
            chk("rst_rd_data", bus.rd_data_o, 256'(0));
            tick(1'b0, 1'b0);
        end
        rstn = 1'b0;
        bus.b_idx = 5'd1;
        tick(1'b0, 1'b1);                       // B wins first
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        tick(1'b0, 1'b0);

        // Solo A locked burst of 8, then B waits behind the burst
        bus.a_req = 1'b1; bus.a_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.a_idx = 5'(i);
            tick(1'b1, 1'b0);
        end
        bus.b_req = 1'b1; bus.b_idx = 5'd2;
        for (int i = 8; i < 11; i++) begin
            bus.a_idx = 5'(i);
            tick(1'b1, 1'b0);
        end
        bus.a_lock = 1'b0; bus.a_idx = 5'd11;
        tick(1'b1, 1'b0);                       // lock drop cycle still grants A
        bus.a_req = 1'b0; bus.b_idx = 5'd3;
        tick(1'b0, 1'b1);
        bus.b_req = 1'b0;
        tick(1'b0, 1'b0);

        // B locked burst starves A; forced A grant once back in IDLE
        bus.a_req = 1'b1; bus.a_idx = 5'd12;
        bus.b_req = 1'b1; bus.b_lock = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.b_idx = 5'(i);
            tick(1'b0, 1'b1);
        end
        bus.b_lock = 1'b0; bus.b_idx = 5'd17;
        tick(1'b0, 1'b1);
        bus.a_idx = 5'd13; bus.b_idx = 5'd18;
        tick(1'b1, 1'b0);
        chk("starve_clr", 256'(u_dut.starve_q), 256'(0));
        // Single-cycle B wins build starvation to exactly 15, then A is forced
        for (int i = 0; i < 15; i++) begin
            bus.b_idx = 5'(i + 10);
            tick(1'b0, 1'b1);
        end
        bus.a_idx = 5'd14;
        tick(1'b1, 1'b0);
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        tick(1'b0, 1'b0);

        // Alternating single-cycle grants
        for (int i = 0; i < 2; i++) begin
            bus.a_req = 1'b1; bus.b_req = 1'b0; bus.a_idx = 5'(24 + i);
            tick(1'b1, 1'b0);
            bus.a_req = 1'b0; bus.b_req = 1'b1; bus.b_idx = 5'(28 + i);
            tick(1'b0, 1'b1);
        end
        bus.b_req = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);

        // Reset in the middle of an A burst: in-flight returns are dropped
        bus.a_req = 1'b1; bus.a_lock = 1'b1;
        for (int i = 20; i < 23; i++) begin
            bus.a_idx = 5'(i);
            tick(1'b1, 1'b0);
        end
        rstn = 1'b1;
        foreach (sb_q[k]) if (sb_q[k].at_cyc <= cyc) keep.push_back(sb_q[k]);
        sb_q = keep;
        tick(1'b0, 1'b0);
        rstn = 1'b0;
`ifdef MD_ARB_STAT_EN
        chk("stat_a", 256'(stat_a_cnt), 256'(0));
        chk("stat_b", 256'(stat_b_cnt), 256'(0));
        chk("stat_peak", 256'(stat_starve_max), 256'(0));
`endif
        bus.a_req = 1'b0; bus.a_lock = 1'b0;
        bus.b_req = 1'b1; bus.b_idx = 5'd31;
        tick(1'b0, 1'b1);                       // FSM back in IDLE
        bus.b_req = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);

        chk("sb_drain", 256'(sb_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
